// File: rtl/network_interface_pkg.sv
// Shared NoC packet definitions for the tile network interface.
// The packet is a 16-bit word: payload over source and destination coordinates.
package pa_noc;

  localparam int PACKET_WIDTH  = 16;
  localparam int PAYLOAD_WIDTH = PACKET_WIDTH - 8;
  localparam int PKT_COORD_W   = 2;

  localparam int DEST_COL_LSB = 0;
  localparam int DEST_ROW_LSB = 2;
  localparam int SRC_COL_LSB  = 4;
  localparam int SRC_ROW_LSB  = 6;
  localparam int PAYLOAD_LSB  = 8;

  typedef struct packed {
    logic [PAYLOAD_WIDTH-1:0] payload;
    logic [PKT_COORD_W-1:0]   srcRow;
    logic [PKT_COORD_W-1:0]   srcCol;
    logic [PKT_COORD_W-1:0]   destRow;
    logic [PKT_COORD_W-1:0]   destCol;
  } noc_packet_t;

  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_HOLD  = 1'b1
  } tx_state_e;

  function automatic logic [PACKET_WIDTH-1:0] build_packet(
    input logic [PAYLOAD_WIDTH-1:0] payload,
    input logic [PKT_COORD_W-1:0]   src_row,
    input logic [PKT_COORD_W-1:0]   src_col,
    input logic [PKT_COORD_W-1:0]   dest_row,
    input logic [PKT_COORD_W-1:0]   dest_col
  );
    logic [PACKET_WIDTH-1:0] pkt;
    pkt = '0;
    pkt[PAYLOAD_LSB  +: PAYLOAD_WIDTH] = payload;
    pkt[SRC_ROW_LSB  +: PKT_COORD_W]   = src_row;
    pkt[SRC_COL_LSB  +: PKT_COORD_W]   = src_col;
    pkt[DEST_ROW_LSB +: PKT_COORD_W]   = dest_row;
    pkt[DEST_COL_LSB +: PKT_COORD_W]   = dest_col;
    return pkt;
  endfunction

endpackage

// File: rtl/network_interface_fifo.sv
// First-word-fall-through FIFO used as the NI receive buffer.
// Carries no occupancy flags; the owner tracks fill level and gates wr/rd.
module synchronousFifo #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage is not reset; the owner never presents a slot it has not written.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/network_interface.sv
// Tile-side NoC endpoint: TX holding register into the router NI FIFO, RX buffer out to the core.
// Define NI_RX_DEST_CHECK_EN to drop (and flag) ejected packets addressed to another tile.
module network_interface
  import pa_noc::*;
#(
  parameter int GRID_WIDTH = 4,
  parameter int RX_ADDR_W  = 2,
  parameter int ROUTER_ROW = 0,
  parameter int ROUTER_COL = 0,
  localparam int COORD_W   = $clog2(GRID_WIDTH)
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_txValid,
  output logic                     o_txReady,
  input  logic [COORD_W-1:0]       i_txDestRow,
  input  logic [COORD_W-1:0]       i_txDestCol,
  input  logic [PAYLOAD_WIDTH-1:0] i_txPayload,
  output logic [PACKET_WIDTH-1:0]  o_router,
  output logic                     o_routerValid,
  input  logic                     i_routerReady,
  input  logic [PACKET_WIDTH-1:0]  i_router,
  input  logic                     i_routerValid,
  output logic                     o_routerReady,
  output logic                     o_rxValid,
  input  logic                     i_rxReady,
  output logic [PAYLOAD_WIDTH-1:0] o_rxPayload,
  output logic [COORD_W-1:0]       o_rxSrcRow,
  output logic [COORD_W-1:0]       o_rxSrcCol,
  output logic                     o_rxOverflow,
  output logic                     o_rxMisroute
);

  // TX state | meaning
  // EMPTY    | no packet held, core may hand one over
  // HOLD     | packet held, sent on the first cycle the router is ready
  localparam logic [PKT_COORD_W-1:0] MY_ROW = PKT_COORD_W'(ROUTER_ROW);
  localparam logic [PKT_COORD_W-1:0] MY_COL = PKT_COORD_W'(ROUTER_COL);
  localparam logic [RX_ADDR_W:0]     DEPTH_CNT = {1'b1, {RX_ADDR_W{1'b0}}};

  tx_state_e               tx_state_q;
  logic [PACKET_WIDTH-1:0] tx_pkt_q;
  logic [PACKET_WIDTH-1:0] tx_pkt_d;
  logic                    tx_send;

  assign tx_send  = (tx_state_q == TX_HOLD) && i_routerReady;
  assign tx_pkt_d = build_packet(i_txPayload, MY_ROW, MY_COL, i_txDestRow, i_txDestCol);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      tx_state_q <= TX_EMPTY;
      tx_pkt_q   <= '0;
    end else begin
      case (tx_state_q)
        TX_EMPTY: begin
          if (i_txValid) begin
            tx_pkt_q   <= tx_pkt_d;
            tx_state_q <= TX_HOLD;
          end
        end
        TX_HOLD: begin
          if (tx_send) begin
            if (i_txValid) tx_pkt_q   <= tx_pkt_d;
            else           tx_state_q <= TX_EMPTY;
          end
        end
        default: tx_state_q <= TX_EMPTY;
      endcase
    end
  end

  // The router FIFO writes on valid alone, so valid is qualified by its ready.
  assign o_txReady     = (tx_state_q == TX_EMPTY) || tx_send;
  assign o_routerValid = tx_send;
  assign o_router      = tx_send ? tx_pkt_q : '0;

  logic [RX_ADDR_W:0]      rx_count_q;
  logic [RX_ADDR_W:0]      rx_count_d;
  logic [RX_ADDR_W:0]      rx_inflight;
  logic                    rx_overflow_q;
  logic                    rx_misroute;
  logic                    rx_push_req;
  logic                    rx_push;
  logic                    rx_pop;
  logic                    rx_full;
  logic [PACKET_WIDTH-1:0] rx_head_raw;
  noc_packet_t             rx_head;
  logic                    unused_head_dest;

`ifdef NI_RX_DEST_CHECK_EN
  noc_packet_t rx_in;
  logic        rx_misroute_q;

  assign rx_in       = noc_packet_t'(i_router);
  assign rx_misroute = i_routerValid && ((rx_in.destRow != MY_ROW) || (rx_in.destCol != MY_COL));

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) rx_misroute_q <= 1'b0;
    else if (rx_misroute) rx_misroute_q <= 1'b1;
  end

  assign o_rxMisroute = rx_misroute_q;
`else
  assign rx_misroute  = 1'b0;
  assign o_rxMisroute = 1'b0;
`endif

  assign rx_push_req = i_routerValid && !rx_misroute;
  assign o_rxValid   = (rx_count_q != '0);
  assign rx_pop      = o_rxValid && i_rxReady;
  assign rx_full     = (rx_count_q == DEPTH_CNT);
  // A pop frees the head slot in the same cycle, so a full buffer can still take a push.
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);

  // Counts a strobe already on the wire, since the router saw ready one cycle earlier.
  assign rx_inflight   = rx_count_q + {{RX_ADDR_W{1'b0}}, i_routerValid};
  assign o_routerReady = (rx_inflight < DEPTH_CNT);

  always_comb begin
    rx_count_d = rx_count_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + 1'b1;
      2'b01:   rx_count_d = rx_count_q - 1'b1;
      default: rx_count_d = rx_count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rx_count_q    <= '0;
      rx_overflow_q <= 1'b0;
    end else begin
      rx_count_q <= rx_count_d;
      if (rx_push_req && rx_full && !rx_pop) rx_overflow_q <= 1'b1;
    end
  end

  assign o_rxOverflow = rx_overflow_q;

  synchronousFifo #(
    .DATA_W (PACKET_WIDTH),
    .ADDR_W (RX_ADDR_W)
  ) u_rx_fifo (
    .clk_i     (i_clk),
    .rst_ni    (i_arst_n),
    .wr_en_i   (rx_push),
    .wr_data_i (i_router),
    .rd_en_i   (rx_pop),
    .rd_data_o (rx_head_raw)
  );

  assign rx_head          = noc_packet_t'(rx_head_raw);
  assign unused_head_dest = ^{rx_head.destRow, rx_head.destCol};

  assign o_rxPayload = o_rxValid ? rx_head.payload : '0;
  assign o_rxSrcRow  = o_rxValid ? rx_head.srcRow  : '0;
  assign o_rxSrcCol  = o_rxValid ? rx_head.srcCol  : '0;

endmodule

// File: tb/tb_network_interface.sv
// Directed bench for network_interface at tile (1,2) with a 4-deep RX buffer.
// Expected TX/RX packets are queued when driven and compared when the DUT presents them.
module tb_network_interface;
  import pa_noc::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [1:0]  tx_dest_row = '0;
  logic [1:0]  tx_dest_col = '0;
  logic [7:0]  tx_payload = '0;
  logic [15:0] router_out;
  logic        router_out_valid;
  logic        router_ready = 1'b0;
  logic [15:0] router_in = '0;
  logic        router_in_valid = 1'b0;
  logic        ni_ready;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_payload;
  logic [1:0]  rx_src_row;
  logic [1:0]  rx_src_col;
  logic        rx_overflow;
  logic        rx_misroute;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  logic [15:0] rx_pkts[4];

  always #5 clk = ~clk;

  network_interface #(
    .GRID_WIDTH (4),
    .RX_ADDR_W  (2),
    .ROUTER_ROW (1),
    .ROUTER_COL (2)
  ) dut (
    .i_clk         (clk),
    .i_arst_n      (rst_n),
    .i_txValid     (tx_valid),
    .o_txReady     (tx_ready),
    .i_txDestRow   (tx_dest_row),
    .i_txDestCol   (tx_dest_col),
    .i_txPayload   (tx_payload),
    .o_router      (router_out),
    .o_routerValid (router_out_valid),
    .i_routerReady (router_ready),
    .i_router      (router_in),
    .i_routerValid (router_in_valid),
    .o_routerReady (ni_ready),
    .o_rxValid     (rx_valid),
    .i_rxReady     (rx_ready),
    .o_rxPayload   (rx_payload),
    .o_rxSrcRow    (rx_src_row),
    .o_rxSrcCol    (rx_src_col),
    .o_rxOverflow  (rx_overflow),
    .o_rxMisroute  (rx_misroute)
  );

  function automatic logic [15:0] mk(input logic [7:0] p, input logic [1:0] sr, input logic [1:0] sc,
                                     input logic [1:0] dr, input logic [1:0] dc);
    return {p, sr, sc, dr, dc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_tx(input logic exp_valid);
    logic [15:0] e;
    e = 16'h0;
    if (exp_valid) e = (tx_q.size() > 0) ? tx_q.pop_front() : 16'hxxxx;
    chk("tx_valid", {31'd0, router_out_valid}, {31'd0, exp_valid});
    chk("tx_packet", {16'd0, router_out}, {16'd0, e});
  endtask

  task automatic expect_rx(input logic exp_valid);
    logic [15:0] e;
    e = 16'h0;
    if (exp_valid) e = (rx_q.size() > 0) ? rx_q[0] : 16'hxxxx;
    chk("rx_valid", {31'd0, rx_valid}, {31'd0, exp_valid});
    chk("rx_payload", {24'd0, rx_payload}, {24'd0, e[15:8]});
    chk("rx_src_row", {30'd0, rx_src_row}, {30'd0, e[7:6]});
    chk("rx_src_col", {30'd0, rx_src_col}, {30'd0, e[5:4]});
  endtask

  task automatic expect_reset_state(input string tag);
    chk({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
    chk({tag, "_router"}, {16'd0, router_out}, 32'd0);
    chk({tag, "_router_valid"}, {31'd0, router_out_valid}, 32'd0);
    chk({tag, "_ni_ready"}, {31'd0, ni_ready}, 32'd1);
    chk({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    chk({tag, "_overflow"}, {31'd0, rx_overflow}, 32'd0);
    chk({tag, "_misroute"}, {31'd0, rx_misroute}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    rx_pkts[0] = mk(8'h3C, 2'd0, 2'd0, 2'd1, 2'd2);
    rx_pkts[1] = mk(8'h5B, 2'd1, 2'd0, 2'd1, 2'd2);
    rx_pkts[2] = mk(8'h77, 2'd3, 2'd3, 2'd1, 2'd2);
    rx_pkts[3] = mk(8'h90, 2'd2, 2'd1, 2'd1, 2'd2);

    repeat (2) @(posedge clk);
    #1;
    expect_reset_state("por");
    rst_n = 1'b1;
    step();

    // Single packet, router ready: one valid pulse.
    tx_valid = 1'b1; tx_dest_row = 2'd3; tx_dest_col = 2'd0; tx_payload = 8'hA5;
    router_ready = 1'b1;
    tx_q.push_back(mk(8'hA5, 2'd1, 2'd2, 2'd3, 2'd0));
    #1;
    chk("tx_ready_empty", {31'd0, tx_ready}, 32'd1);
    expect_tx(1'b0);
    step();
    tx_valid = 1'b0;
    #1;
    expect_tx(1'b1);
    step();
    expect_tx(1'b0);
    chk("tx_ready_idle", {31'd0, tx_ready}, 32'd1);

    // Router backpressure while holding.
    router_ready = 1'b0;
    tx_valid = 1'b1;
    tx_q.push_back(mk(8'hA5, 2'd1, 2'd2, 2'd3, 2'd0));
    step();
    tx_valid = 1'b0;
    repeat (3) begin
      #1;
      expect_tx(1'b0);
      chk("tx_ready_hold", {31'd0, tx_ready}, 32'd0);
      step();
    end
    router_ready = 1'b1;
    #1;
    expect_tx(1'b1);
    chk("tx_ready_send", {31'd0, tx_ready}, 32'd1);
    step();
    expect_tx(1'b0);

    // Back-to-back reload at one packet per cycle.
    tx_valid = 1'b1; tx_dest_row = 2'd0; tx_dest_col = 2'd3; tx_payload = 8'h11;
    tx_q.push_back(mk(8'h11, 2'd1, 2'd2, 2'd0, 2'd3));
    step();
    tx_dest_row = 2'd2; tx_dest_col = 2'd1; tx_payload = 8'h22;
    tx_q.push_back(mk(8'h22, 2'd1, 2'd2, 2'd2, 2'd1));
    #1;
    expect_tx(1'b1);
    chk("tx_ready_b2b", {31'd0, tx_ready}, 32'd1);
    step();
    tx_valid = 1'b0;
    #1;
    expect_tx(1'b1);
    step();
    expect_tx(1'b0);

    // Fill the RX buffer with the core stalled.
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      router_in = rx_pkts[i];
      router_in_valid = 1'b1;
      rx_q.push_back(rx_pkts[i]);
      #1;
      chk("ni_ready_fill", {31'd0, ni_ready}, (i < 3) ? 32'd1 : 32'd0);
      step();
      router_in_valid = 1'b0;
      #1;
      expect_rx(1'b1);
    end
    chk("ni_ready_full", {31'd0, ni_ready}, 32'd0);

    // Push into a full buffer is dropped and flagged.
    router_in = mk(8'hEE, 2'd0, 2'd1, 2'd1, 2'd2);
    router_in_valid = 1'b1;
    step();
    router_in_valid = 1'b0;
    #1;
    chk("overflow_set", {31'd0, rx_overflow}, 32'd1);
    expect_rx(1'b1);
    step();
    chk("overflow_sticky", {31'd0, rx_overflow}, 32'd1);

    rx_ready = 1'b1;
    repeat (4) begin
      #1;
      expect_rx(1'b1);
      void'(rx_q.pop_front());
      step();
    end
    rx_ready = 1'b0;
    #1;
    expect_rx(1'b0);
    chk("ni_ready_drained", {31'd0, ni_ready}, 32'd1);

    // Packet addressed to tile (1,1).
    router_in = 16'h1105;
    router_in_valid = 1'b1;
`ifndef NI_RX_DEST_CHECK_EN
    rx_q.push_back(16'h1105);
`endif
    step();
    router_in_valid = 1'b0;
    #1;
`ifdef NI_RX_DEST_CHECK_EN
    expect_rx(1'b0);
    chk("misroute_set", {31'd0, rx_misroute}, 32'd1);
`else
    expect_rx(1'b1);
    chk("misroute_off", {31'd0, rx_misroute}, 32'd0);
    rx_ready = 1'b1;
    step();
    void'(rx_q.pop_front());
    rx_ready = 1'b0;
    #1;
    expect_rx(1'b0);
`endif

    // Reset with a held TX packet and two RX entries.
    router_ready = 1'b0;
    tx_valid = 1'b1; tx_dest_row = 2'd0; tx_dest_col = 2'd0; tx_payload = 8'h5A;
    step();
    tx_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      router_in = rx_pkts[i];
      router_in_valid = 1'b1;
      rx_q.push_back(rx_pkts[i]);
      step();
    end
    router_in_valid = 1'b0;
    #1;
    chk("pre_reset_hold", {31'd0, tx_ready}, 32'd0);
    expect_rx(1'b1);
    rst_n = 1'b0;
    router_ready = 1'b1;
    step();
    expect_reset_state("midrst");
    chk("midrst_payload", {24'd0, rx_payload}, 32'd0);
    rst_n = 1'b1;
    tx_q.delete();
    rx_q.delete();
    step();
    expect_tx(1'b0);
    expect_rx(1'b0);
    chk("post_reset_tx_ready", {31'd0, tx_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
